// File: rtl/clk_en_nco_pkg.sv
`default_nettype none
// ============================================================================
// Module  : clk_en_nco_pkg
// Brief   : Shared types and helpers for the clk_en_nco enable generator.
// Revision: 1.0
// ============================================================================
package clk_en_nco_pkg;

  // Widest supported accumulator; the config record is sized for it.
  localparam int ACC_MAX = 48;

  typedef enum logic [0:0] {
    SETTLE = 1'b0,
    LOCKED = 1'b1
  } lock_state_t;

  typedef struct packed {
    logic [ACC_MAX-1:0] inc;
    logic [ACC_MAX-1:0] phase;
    logic               run;
  } nco_cfg_t;

  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/nco_channel.sv
`default_nettype none
// ============================================================================
// Module  : nco_channel
// Brief   : One phase-accumulator channel producing a ce pulse and sq strobe.
// Revision: 1.0
// ============================================================================
module nco_channel
  import clk_en_nco_pkg::*;
#(
  parameter int ACC_WIDTH = 32
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     wr_en,
  input  nco_cfg_t wr_cfg,
  input  logic     restart,
  output logic     ce,
  output logic     sq
);

  logic [ACC_WIDTH-1:0] inc_q, inc_d;
  logic [ACC_WIDTH-1:0] phase_q, phase_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic                 run_q, run_d;
  logic                 ce_q, ce_d;
  logic                 sq_q, sq_d;
  logic [ACC_WIDTH:0]   sum;

  // Bits of the shared record above ACC_WIDTH carry no information here.
  logic unused_cfg_hi;
  assign unused_cfg_hi = ^{wr_cfg.inc >> ACC_WIDTH, wr_cfg.phase >> ACC_WIDTH};

  always_comb begin
    inc_d   = inc_q;
    phase_d = phase_q;
    run_d   = run_q;
    acc_d   = acc_q;
    ce_d    = 1'b0;
    sq_d    = sq_q;
    sum     = {1'b0, acc_q} + {1'b0, inc_q};

    if (wr_en) begin
      inc_d   = wr_cfg.inc[ACC_WIDTH-1:0];
      phase_d = wr_cfg.phase[ACC_WIDTH-1:0];
      run_d   = wr_cfg.run;
    end

    // A restart in the commit cycle sees the freshly written phase/run.
    if (run_d && (wr_en || restart)) begin
      acc_d = phase_d;
    end else if (wr_en) begin
      sq_d = 1'b0;
    end else if (run_q) begin
      acc_d = sum[ACC_WIDTH-1:0];
      ce_d  = sum[ACC_WIDTH];
      if (sum[ACC_WIDTH]) begin
        sq_d = ~sq_q;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inc_q   <= '0;
      phase_q <= '0;
      acc_q   <= '0;
      run_q   <= 1'b0;
      ce_q    <= 1'b0;
      sq_q    <= 1'b0;
    end else begin
      inc_q   <= inc_d;
      phase_q <= phase_d;
      acc_q   <= acc_d;
      run_q   <= run_d;
      ce_q    <= ce_d;
      sq_q    <= sq_d;
    end
  end

  assign ce = ce_q;
  assign sq = sq_q;

endmodule
`default_nettype wire

// File: rtl/clk_en_nco.sv
`default_nettype none
// ============================================================================
// Module  : clk_en_nco
// Brief   : Multi-channel NCO clock-enable generator with config port and lock.
// Revision: 1.0
// ============================================================================
module clk_en_nco
  import clk_en_nco_pkg::*;
#(
  parameter int NUM_CHANNELS = 3,
  parameter int ACC_WIDTH    = 32,
  parameter int LOCK_CYCLES  = 256
) (
  input  logic                                refclk,
  input  logic                                rst,
  input  logic                                cfg_valid,
  output logic                                cfg_ready,
  input  logic [ch_width(NUM_CHANNELS)-1:0]   cfg_channel,
  input  logic [ACC_WIDTH-1:0]                cfg_inc,
  input  logic [ACC_WIDTH-1:0]                cfg_phase,
  input  logic                                cfg_run,
  input  logic                                sync_restart,
  output logic [NUM_CHANNELS-1:0]             ce,
  output logic [NUM_CHANNELS-1:0]             sq,
  output logic                                locked
);

  localparam int CNT_W = $clog2(LOCK_CYCLES + 1);

  logic             cfg_ready_q, cfg_ready_d;
  lock_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept;
  logic             chan_ok;
  logic             disturb;
  nco_cfg_t         wr_cfg;

  always_comb begin
    accept       = cfg_valid && cfg_ready_q;
    chan_ok      = int'(cfg_channel) < NUM_CHANNELS;
    disturb      = sync_restart || (accept && chan_ok);
    cfg_ready_d  = !accept;
    wr_cfg.inc   = ACC_MAX'(cfg_inc);
    wr_cfg.phase = ACC_MAX'(cfg_phase);
    wr_cfg.run   = cfg_run;
  end

  // Lock tracking: any disturbance restarts the quiet-period count.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (disturb) begin
      state_d = SETTLE;
      cnt_d   = '0;
    end else if (state_q == SETTLE) begin
      if (cnt_q == CNT_W'(LOCK_CYCLES - 1)) begin
        state_d = LOCKED;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      cfg_ready_q <= 1'b1;
      state_q     <= SETTLE;
      cnt_q       <= '0;
    end else begin
      cfg_ready_q <= cfg_ready_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
    end
  end

  assign cfg_ready = cfg_ready_q;
  assign locked    = (state_q == LOCKED);

  for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_chan
    logic wr_en;
    assign wr_en = accept && (int'(cfg_channel) == i);

    nco_channel #(
      .ACC_WIDTH (ACC_WIDTH)
    ) u_chan (
      .clk     (refclk),
      .rst     (rst),
      .wr_en   (wr_en),
      .wr_cfg  (wr_cfg),
      .restart (sync_restart),
      .ce      (ce[i]),
      .sq      (sq[i])
    );
  end

endmodule
`default_nettype wire

// File: tb/tb_clk_en_nco.sv
`default_nettype none
// ============================================================================
// Module  : tb_clk_en_nco
// Brief   : Self-checking bench for clk_en_nco against a behavioural model.
// Revision: 1.0
// ============================================================================
module tb_clk_en_nco;

  localparam int NCH  = 3;
  localparam int AW   = 8;
  localparam int LOCK = 4;
  localparam int MOD  = 1 << AW;

  logic          refclk = 1'b0;
  logic          rst;
  logic          cfg_valid;
  logic          cfg_ready;
  logic [1:0]    cfg_channel;
  logic [AW-1:0] cfg_inc;
  logic [AW-1:0] cfg_phase;
  logic          cfg_run;
  logic          sync_restart;
  logic [NCH-1:0] ce;
  logic [NCH-1:0] sq;
  logic          locked;

  int checks = 0;
  int errors = 0;

  clk_en_nco #(
    .NUM_CHANNELS (NCH),
    .ACC_WIDTH    (AW),
    .LOCK_CYCLES  (LOCK)
  ) dut (
    .refclk       (refclk),
    .rst          (rst),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .cfg_channel  (cfg_channel),
    .cfg_inc      (cfg_inc),
    .cfg_phase    (cfg_phase),
    .cfg_run      (cfg_run),
    .sync_restart (sync_restart),
    .ce           (ce),
    .sq           (sq),
    .locked       (locked)
  );

  always #5 refclk = ~refclk;

  // Behavioural model: integer phase arithmetic modulo 2^AW.
  int       m_inc   [NCH];
  int       m_phase [NCH];
  int       m_acc   [NCH];
  bit       m_run   [NCH];
  bit [NCH-1:0] m_ce;
  bit [NCH-1:0] m_sq;
  bit       m_ready;
  int       m_quiet;

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_inc[i] = 0; m_phase[i] = 0; m_acc[i] = 0; m_run[i] = 1'b0;
    end
    m_ce = '0; m_sq = '0; m_ready = 1'b1; m_quiet = 0;
  endtask

  task automatic model_step();
    bit taken;
    int ch;
    int total;
    taken = cfg_valid && m_ready;
    ch    = int'(cfg_channel);
    if (taken && ch < NCH) begin
      m_inc[ch] = int'(cfg_inc); m_phase[ch] = int'(cfg_phase); m_run[ch] = cfg_run;
    end
    for (int i = 0; i < NCH; i++) begin
      bit wrote;
      wrote = taken && (ch == i);
      m_ce[i] = 1'b0;
      if (m_run[i] && (wrote || sync_restart)) begin
        m_acc[i] = m_phase[i];
      end else if (wrote) begin
        m_sq[i] = 1'b0;
      end else if (m_run[i]) begin
        total = m_acc[i] + m_inc[i];
        m_acc[i] = total % MOD;
        if (total >= MOD) begin
          m_ce[i] = 1'b1;
          m_sq[i] = ~m_sq[i];
        end
      end
    end
    if (sync_restart || (taken && ch < NCH)) m_quiet = 0;
    else if (m_quiet < LOCK) m_quiet++;
    m_ready = !taken;
  endtask

  function automatic logic [7:0] exp_vec();
    return {m_ce, m_sq, (m_quiet >= LOCK), m_ready};
  endfunction

  function automatic logic [7:0] dut_vec();
    return {ce, sq, locked, cfg_ready};
  endfunction

  // Advance one edge; leaves time at 1 unit after the rising edge.
  task automatic tick();
    model_step();
    @(posedge refclk);
    #1;
  endtask

  task automatic write_tick(input int ch, input int inc, input int ph, input bit run,
                            input bit rs);
    cfg_valid    = 1'b1;
    cfg_channel  = 2'(ch);
    cfg_inc      = AW'(inc);
    cfg_phase    = AW'(ph);
    cfg_run      = run;
    sync_restart = rs;
    tick();
    cfg_valid    = 1'b0;
    sync_restart = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; cfg_valid = 1'b0; cfg_channel = '0; cfg_inc = '0;
    cfg_phase = '0; cfg_run = 1'b0; sync_restart = 1'b0;
    model_reset();
    #22;
    checks++;
    if (dut_vec() !== 8'b000_000_0_1) begin
      errors++;
      $display("FAIL reset_state: got %b want %b", dut_vec(), 8'b000_000_0_1);
    end
    rst = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      checks++;
      if ({ce, sq, cfg_ready, locked} !== {6'b0, 1'b1, (k >= LOCK)}) begin
        errors++;
        $display("FAIL reset_release k=%0d: ce=%b sq=%b rdy=%b lock=%b want lock=%0d",
                 k, ce, sq, cfg_ready, locked, (k >= LOCK));
      end
    end
  endtask

  task automatic test_basic();
    write_tick(0, 'h40, 0, 1'b1, 1'b0);
    checks++;
    if (cfg_ready !== 1'b0 || locked !== 1'b0) begin
      errors++;
      $display("FAIL basic_handshake: rdy=%b lock=%b want 0 0", cfg_ready, locked);
    end
    for (int t = 1; t <= 20; t++) begin
      tick();
      checks++;
      if (ce[0] !== (t % 4 == 0) || sq[0] !== ((t / 4) % 2 == 1) ||
          locked !== (t >= LOCK) || cfg_ready !== 1'b1) begin
        errors++;
        $display("FAIL basic_ch0 t=%0d: ce0=%b sq0=%b lock=%b rdy=%b", t, ce[0], sq[0],
                 locked, cfg_ready);
      end
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL basic_model t=%0d: got %b want %b", t, dut_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_alternate();
    write_tick(1, 'h80, 'h80, 1'b1, 1'b0);
    tick();
    write_tick(2, 'h80, 0, 1'b1, 1'b0);
    tick();
    sync_restart = 1'b1;
    tick();
    sync_restart = 1'b0;
    for (int t = 1; t <= 12; t++) begin
      tick();
      checks++;
      if (ce[1] === ce[2] || ce[1] !== (t % 2 == 1)) begin
        errors++;
        $display("FAIL alternate t=%0d: ce1=%b ce2=%b", t, ce[1], ce[2]);
      end
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL alternate_model t=%0d: got %b want %b", t, dut_vec(), exp_vec());
      end
    end
    // Restart coincident with a ch2 commit: ch2 takes its new phase 0x80.
    write_tick(2, 'h80, 'h80, 1'b1, 1'b1);
    for (int t = 1; t <= 6; t++) begin
      tick();
      checks++;
      if (ce[1] !== ce[2] || ce[1] !== (t % 2 == 1)) begin
        errors++;
        $display("FAIL restart_commit t=%0d: ce1=%b ce2=%b", t, ce[1], ce[2]);
      end
    end
  endtask

  task automatic test_edge_inc();
    int cnt;
    int mism;
    write_tick(0, 0, 'h10, 1'b1, 1'b0);
    cnt = 0; mism = 0;
    for (int t = 0; t < 1000; t++) begin
      tick();
      if (ce[0]) cnt++;
      if (dut_vec() !== exp_vec()) mism++;
    end
    checks++;
    if (cnt !== 0) begin
      errors++;
      $display("FAIL inc_zero: pulses=%0d want 0", cnt);
    end
    checks++;
    if (mism !== 0) begin
      errors++;
      $display("FAIL inc_zero_model: mismatching cycles=%0d want 0", mism);
    end
    write_tick(0, 'hFF, 0, 1'b1, 1'b0);
    cnt = 0;
    for (int t = 0; t < 256; t++) begin
      tick();
      if (ce[0]) cnt++;
    end
    checks++;
    if (cnt !== 255) begin
      errors++;
      $display("FAIL inc_max: pulses=%0d want 255", cnt);
    end
  endtask

  task automatic test_bad_channel();
    int n;
    n = 0;
    while (!locked && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (locked !== 1'b1) begin
      errors++;
      $display("FAIL bad_ch_wait_lock: lock=%b want 1 (timeout)", locked);
    end
    write_tick(3, 'h11, 'h22, 1'b1, 1'b0);
    checks++;
    if (cfg_ready !== 1'b0 || locked !== 1'b1) begin
      errors++;
      $display("FAIL bad_ch_accept: rdy=%b lock=%b want 0 1", cfg_ready, locked);
    end
    for (int t = 1; t <= 10; t++) begin
      tick();
      checks++;
      if (dut_vec() !== exp_vec() || cfg_ready !== 1'b1 || locked !== 1'b1) begin
        errors++;
        $display("FAIL bad_ch_after t=%0d: got %b want %b", t, dut_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_random();
    for (int t = 0; t < 600; t++) begin
      cfg_valid    = ($urandom_range(1) == 1);
      cfg_channel  = 2'($urandom_range(3));
      cfg_inc      = AW'($urandom);
      cfg_phase    = AW'($urandom);
      cfg_run      = ($urandom_range(3) != 0);
      sync_restart = ($urandom_range(15) == 0);
      tick();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL random t=%0d: got %b want %b", t, dut_vec(), exp_vec());
      end
    end
    cfg_valid = 1'b0; sync_restart = 1'b0;
    tick();
  endtask

  task automatic test_reset_midrun();
    write_tick(0, 'h40, 0, 1'b1, 1'b0);
    write_tick(1, 'h80, 0, 1'b1, 1'b0);
    write_tick(2, 'h20, 0, 1'b1, 1'b0);
    for (int t = 0; t < 13; t++) tick();
    checks++;
    if (dut_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL pre_reset: got %b want %b", dut_vec(), exp_vec());
    end
    #2 rst = 1'b1;
    #1;
    model_reset();
    checks++;
    if (ce !== '0 || sq !== '0 || locked !== 1'b0 || cfg_ready !== 1'b1) begin
      errors++;
      $display("FAIL async_reset: ce=%b sq=%b lock=%b rdy=%b want 000 000 0 1",
               ce, sq, locked, cfg_ready);
    end
    #3 rst = 1'b0;
    for (int t = 1; t <= 20; t++) begin
      tick();
      checks++;
      if (ce !== '0 || sq !== '0 || dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL post_reset t=%0d: got %b want %b", t, dut_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_alternate();
    test_edge_inc();
    test_bad_channel();
    test_random();
    test_reset_midrun();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
